// File: rtl/line_buffer_pkg.sv
// Shared types and constants for the Sobel line-buffer front end.
package line_buffer_pkg;

    // Default pixel width; the controller itself is parameterised separately.
    localparam int PIXEL_W_DEFAULT = 8;

    // Row state saturates here: two complete lines are held in the RAMs.
    localparam logic [1:0] ROWS_FULL = 2'd2;

    typedef logic [PIXEL_W_DEFAULT-1:0] pixel_t;

    // One vertical 3-pixel column as seen by the window stage.
    typedef struct packed {
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
    } column_t;

    // True once the row state shows that top and mid hold real data.
    function automatic logic rows_full(input logic [1:0] row);
        return (row == ROWS_FULL);
    endfunction

endpackage

// File: rtl/line_buffer_counter.sv
// Raster position tracker: column counter with wrap, saturating row counter,
// and a start-of-frame override that forces x=0,row=0 for the current pixel.
module line_buffer_counter
    import line_buffer_pkg::*;
#(
    parameter int LINE_WIDTH_P = 640,
    parameter int COL_W        = $clog2(LINE_WIDTH_P)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             accept_i,
    input  logic             sof_i,
    output logic [COL_W-1:0] col_o,
    output logic [1:0]       row_o
);

    logic [COL_W-1:0] col_r;
    logic [1:0]       row_r;
    logic [COL_W-1:0] cur_col_s;
    logic [1:0]       cur_row_s;
    logic [COL_W-1:0] next_col_s;
    logic [1:0]       next_row_s;
    logic             wrap_s;

    // Effective position of the pixel being accepted and the position after it.
    always_comb begin
        cur_col_s  = col_r;
        cur_row_s  = row_r;
        next_col_s = col_r;
        next_row_s = row_r;
        if (sof_i) begin
            cur_col_s = '0;
            cur_row_s = 2'd0;
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        wrap_s = (cur_col_s == COL_W'(LINE_WIDTH_P - 1));
        if (wrap_s) begin
            next_col_s = '0;
            if (cur_row_s != ROWS_FULL) begin
                next_row_s = cur_row_s + 2'd1;
            end else begin
                next_row_s = cur_row_s;
            end
        end else begin
            next_col_s = cur_col_s + COL_W'(1);
            next_row_s = cur_row_s;
        end
    end

    // Position registers advance only on an accepted pixel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_r <= '0;
            row_r <= 2'd0;
        end else if (accept_i) begin
            col_r <= next_col_s;
            row_r <= next_row_s;
        end
    end

    assign col_o = cur_col_s;
    assign row_o = cur_row_s;

endmodule

// File: rtl/sync_ram_block.sv
// Simple dual-port line memory: one write port, one registered read port.
// The read register holds its value whenever rd_en_i is low.
module sync_ram_block #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 640
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH_P)-1:0] wr_addr_i,
    input  logic [WIDTH_P-1:0]         wr_data_i,
    input  logic                       rd_en_i,
    input  logic [$clog2(DEPTH_P)-1:0] rd_addr_i,
    output logic [WIDTH_P-1:0]         data_o
);

    logic [WIDTH_P-1:0] mem_r [DEPTH_P];
    logic [WIDTH_P-1:0] data_r;

    // Memory array write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_r[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            data_r <= '0;
        end else if (rd_en_i) begin
            data_r <= mem_r[rd_addr_i];
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Two-line cascaded line buffer: turns a raster pixel stream into vertical
// 3-pixel columns {y-2, y-1, y} with one cycle of latency.
module line_buffer_ctrl
    import line_buffer_pkg::*;
#(
    parameter int PIXEL_WIDTH_P = 8,
    parameter int LINE_WIDTH_P  = 640,
    localparam int COL_W        = $clog2(LINE_WIDTH_P)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sof_i,
    input  logic [PIXEL_WIDTH_P-1:0] pixel_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [PIXEL_WIDTH_P-1:0] col_top_o,
    output logic [PIXEL_WIDTH_P-1:0] col_mid_o,
    output logic [PIXEL_WIDTH_P-1:0] col_bot_o,
    output logic [COL_W-1:0]         col_x_o,
    output logic                     eol_o,
    output logic                     rows_valid_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    if (LINE_WIDTH_P < 2) begin : g_bad_line_width
        $error("line_buffer_ctrl: LINE_WIDTH_P must be at least 2");
    end

    logic                     ready_s;
    logic                     accept_s;
    logic                     fire_s;
    logic                     ram_rstn_s;
    logic [COL_W-1:0]         cur_col_s;
    logic [1:0]               cur_row_s;
    logic [PIXEL_WIDTH_P-1:0] mid_data_s;
    logic [PIXEL_WIDTH_P-1:0] top_data_s;

    logic                     s1_valid_r;
    logic [PIXEL_WIDTH_P-1:0] s1_bot_r;
    logic [COL_W-1:0]         s1_col_r;
    logic [1:0]               s1_row_r;

    // Single-entry pipeline: S1 can take a new pixel when empty or draining.
    assign ready_s    = ~s1_valid_r | ready_i;
    assign accept_s   = valid_i & ready_s & ~rst_i;
    // A reset cycle drops the S1 entry without committing it to the RAMs.
    assign fire_s     = s1_valid_r & ready_i & ~rst_i;
    assign ram_rstn_s = ~rst_i;

    line_buffer_counter #(
        .LINE_WIDTH_P (LINE_WIDTH_P),
        .COL_W        (COL_W)
    ) u_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .accept_i (accept_s),
        .sof_i    (sof_i),
        .col_o    (cur_col_s),
        .row_o    (cur_row_s)
    );

    // Row y-1: read at accept, rewritten with the current row pixel at fire.
    sync_ram_block #(
        .WIDTH_P (PIXEL_WIDTH_P),
        .DEPTH_P (LINE_WIDTH_P)
    ) ram_mid (
        .clk_i     (clk_i),
        .rstn_i    (ram_rstn_s),
        .wr_en_i   (fire_s),
        .wr_addr_i (s1_col_r),
        .wr_data_i (s1_bot_r),
        .rd_en_i   (accept_s),
        .rd_addr_i (cur_col_s),
        .data_o    (mid_data_s)
    );

    // Row y-2: cascaded from the row y-1 value read out for this column.
    sync_ram_block #(
        .WIDTH_P (PIXEL_WIDTH_P),
        .DEPTH_P (LINE_WIDTH_P)
    ) ram_top (
        .clk_i     (clk_i),
        .rstn_i    (ram_rstn_s),
        .wr_en_i   (fire_s),
        .wr_addr_i (s1_col_r),
        .wr_data_i (mid_data_s),
        .rd_en_i   (accept_s),
        .rd_addr_i (cur_col_s),
        .data_o    (top_data_s)
    );

    // S1 output stage: loads on accept, empties on fire, holds while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s1_bot_r   <= '0;
            s1_col_r   <= '0;
            s1_row_r   <= 2'd0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_bot_r   <= pixel_i;
            s1_col_r   <= cur_col_s;
            s1_row_r   <= cur_row_s;
        end else if (fire_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    assign ready_o      = ready_s;
    assign valid_o      = s1_valid_r;
    assign col_top_o    = top_data_s;
    assign col_mid_o    = mid_data_s;
    assign col_bot_o    = s1_bot_r;
    assign col_x_o      = s1_col_r;
    assign eol_o        = s1_valid_r & (s1_col_r == COL_W'(LINE_WIDTH_P - 1));
    assign rows_valid_o = rows_full(s1_row_r);

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: a stream-history model predicts each
// output column from the pixels accepted since the last frame start.
module tb_line_buffer_ctrl;

    localparam int PW  = 8;
    localparam int W   = 4;
    localparam int CW  = 2;
    localparam int W2  = 2;
    localparam int CW2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          sof_i = 1'b0;
    logic [PW-1:0] pixel_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [PW-1:0] col_top, col_mid, col_bot;
    logic [CW-1:0] col_x;
    logic          eol, rows_valid, valid_o;
    logic          ready_i = 1'b1;

    logic           sof2 = 1'b0;
    logic [PW-1:0]  pix2 = '0;
    logic           valid2 = 1'b0;
    logic           ready2_o;
    logic [PW-1:0]  top2, mid2, bot2;
    logic [CW2-1:0] x2;
    logic           eol2, rv2, vo2;
    logic           ready2_i = 1'b1;

    line_buffer_ctrl #(.PIXEL_WIDTH_P(PW), .LINE_WIDTH_P(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .sof_i(sof_i), .pixel_i(pixel_i),
        .valid_i(valid_i), .ready_o(ready_o), .col_top_o(col_top),
        .col_mid_o(col_mid), .col_bot_o(col_bot), .col_x_o(col_x),
        .eol_o(eol), .rows_valid_o(rows_valid), .valid_o(valid_o),
        .ready_i(ready_i)
    );

    line_buffer_ctrl #(.PIXEL_WIDTH_P(PW), .LINE_WIDTH_P(W2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .sof_i(sof2), .pixel_i(pix2),
        .valid_i(valid2), .ready_o(ready2_o), .col_top_o(top2),
        .col_mid_o(mid2), .col_bot_o(bot2), .col_x_o(x2),
        .eol_o(eol2), .rows_valid_o(rv2), .valid_o(vo2),
        .ready_i(ready2_i)
    );

    typedef struct {
        logic [PW-1:0] top;
        logic [PW-1:0] mid;
        logic [PW-1:0] bot;
        int            col;
        logic          eol;
        logic          rv;
    } exp_t;

    exp_t          sb_q[$];
    logic [PW-1:0] hist_q[$];
    bit            restart = 1'b1;
    int            n_checks = 0;
    int            n_fail = 0;
    longint        cyc = 0;
    longint        acc_cyc = -10;
    int            rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: output k of a frame is pixel k with top/mid being the
    // pixels exactly two and one line-lengths earlier in the same frame.
    task automatic model_accept(input logic [PW-1:0] p, input logic s);
        exp_t e;
        int   idx;
        if (s || restart) begin
            hist_q.delete();
            restart = 1'b0;
        end
        idx = hist_q.size();
        hist_q.push_back(p);
        e.bot = p;
        e.col = idx % W;
        e.eol = ((idx % W) == W - 1);
        e.rv  = (idx >= 2 * W);
        e.top = e.rv ? hist_q[idx - 2 * W] : '0;
        e.mid = e.rv ? hist_q[idx - W] : '0;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ready_i generator
    always @(negedge clk) begin
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(0, 3) != 0);
            2:       ready_i = 1'b0;
            default: ready_i = 1'b1;
        endcase
    end

    // One-cycle latency: the cycle after an accept must present valid_o.
    always @(negedge clk) begin
        if (!rst_i && cyc == acc_cyc + 1) check("latency_valid", valid_o, 1);
    end

    // Monitor: pops on every output fire, checks stability on every stall.
    exp_t          mon_e;
    bit            stall_prev = 1'b0;
    logic [PW-1:0] s_top, s_mid, s_bot;
    logic [CW-1:0] s_x;
    logic          s_eol, s_rv;
    always begin
        @(negedge clk);
        #2;
        if (rst_i) begin
            stall_prev = 1'b0;
        end else if (valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("col_bot", col_bot, mon_e.bot);
                check("col_x", col_x, mon_e.col);
                check("eol", eol, mon_e.eol);
                check("rows_valid", rows_valid, mon_e.rv);
                if (mon_e.rv) begin
                    check("col_top", col_top, mon_e.top);
                    check("col_mid", col_mid, mon_e.mid);
                end
            end
            stall_prev = 1'b0;
        end else if (valid_o && !ready_i) begin
            check("stall_ready_o", ready_o, 0);
            if (stall_prev) begin
                check("stall_top", col_top, s_top);
                check("stall_mid", col_mid, s_mid);
                check("stall_bot", col_bot, s_bot);
                check("stall_x", col_x, s_x);
                check("stall_eol", eol, s_eol);
                check("stall_rv", rows_valid, s_rv);
            end
            s_top = col_top; s_mid = col_mid; s_bot = col_bot;
            s_x = col_x; s_eol = eol; s_rv = rows_valid;
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Present one pixel from the next falling edge until it is accepted.
    task automatic send(input logic [PW-1:0] p, input logic s, input int gap);
        repeat (gap) begin
            @(negedge clk);
            valid_i = 1'b0;
            sof_i   = 1'b0;
        end
        @(negedge clk);
        valid_i = 1'b1;
        pixel_i = p;
        sof_i   = s;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (ready_o) begin
                model_accept(p, s);
                acc_cyc = cyc;
                return;
            end
            @(negedge clk);
        end
        check("accept_timeout", 0, 1);
        valid_i = 1'b0;
    endtask

    task automatic stop_input();
        @(negedge clk);
        valid_i = 1'b0;
        sof_i   = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        // Reset state
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_ready_o", ready_o, 1);
        check("rst_col_x", col_x, 0);
        check("rst_eol", eol, 0);
        check("rst_rows_valid", rows_valid, 0);
        check("rst_top", col_top, 0);
        check("rst_mid", col_mid, 0);
        check("rst_bot", col_bot, 0);
        check("rst_valid2", vo2, 0);
        rst_i   = 1'b0;
        restart = 1'b1;

        // Streaming: three lines of 0..11, sof on pixel 0
        rdy_mode = 0;
        for (int i = 0; i < 12; i++) send(PW'(i), i == 0, 0);
        stop_input();
        drain();

        // Backpressure: 5-cycle stall mid-line
        send(8'd100, 1'b1, 0);
        send(8'd101, 1'b0, 0);
        rdy_mode = 2;
        stop_input();
        repeat (5) @(negedge clk);
        rdy_mode = 0;
        for (int i = 2; i < 12; i++) send(PW'(100 + i), 1'b0, 0);
        stop_input();
        drain();

        // Random valid/ready: 4 frames of 4x6
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 24; i++) begin
                send(PW'($urandom), i == 0, int'($urandom_range(0, 2)));
            end
        end
        stop_input();
        rdy_mode = 0;
        drain();

        // Reset with an entry held in S1
        send(8'd50, 1'b1, 0);
        send(8'd51, 1'b0, 0);
        rdy_mode = 2;
        stop_input();
        @(negedge clk);
        #1;
        check("pre_reset_valid", valid_o, 1);
        @(negedge clk);
        rst_i = 1'b1;
        sb_q.delete();
        restart = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_valid", valid_o, 0);
        check("post_reset_ready", ready_o, 1);
        rst_i    = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) send(PW'(60 + i), 1'b0, 0);
        stop_input();
        drain();

        // sof at x=2 of line 2, then three more lines
        for (int i = 0; i < 10; i++) send(PW'(150 + i), i == 0, 0);
        for (int i = 0; i < 13; i++) send(PW'(200 + i), i == 0, 0);
        stop_input();
        drain();

        // LINE_WIDTH_P=2, fire+accept every cycle for 3 lines
        ready2_i = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k < 6) begin
                valid2 = 1'b1;
                pix2   = PW'(10 + k);
                sof2   = (k == 0);
            end else begin
                valid2 = 1'b0;
                sof2   = 1'b0;
            end
            #1;
            if (k < 6) check("w2_ready", ready2_o, 1);
            if (k > 0) begin
                int j;
                j = k - 1;
                check("w2_valid", vo2, 1);
                check("w2_bot", bot2, 10 + j);
                check("w2_x", x2, j % 2);
                check("w2_eol", eol2, (j % 2) == 1);
                check("w2_rv", rv2, j >= 4);
                if (j >= 4) begin
                    check("w2_top", top2, 10 + j - 4);
                    check("w2_mid", mid2, 10 + j - 2);
                end
            end
        end
        @(negedge clk);
        #1;
        check("w2_idle", vo2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequences two sync_ram_block line memories as a cascaded 2-line buffer for the Sobel front end.
- Accepts a raster pixel stream over a valid/ready handshake.
- Emits one vertical 3-pixel column per accepted pixel: {row y-2, row y-1, row y}, all at the same column x, plus column/row-position flags.
- Sits between the pixel source and the 3x3 window/Sobel kernel.

Parameters:
- PIXEL_WIDTH_P, 8, bits per pixel.
- LINE_WIDTH_P, 640, pixels per line. Legal range is ≥ 2; elaboration error otherwise.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- sof_i  in  1  start of frame; sampled together with the accepted pixel
- pixel_i  in  PIXEL_WIDTH_P  input pixel
- valid_i  in  1  input pixel valid
- ready_o  out  1  block can accept a pixel
- col_top_o  out  PIXEL_WIDTH_P  pixel at row y-2, column x
- col_mid_o  out  PIXEL_WIDTH_P  pixel at row y-1, column x
- col_bot_o  out  PIXEL_WIDTH_P  pixel at row y, column x (the delayed input pixel)
- col_x_o  out  $clog2(LINE_WIDTH_P)  column index of the output
- eol_o  out  1  output column is x = LINE_WIDTH_P-1
- rows_valid_o  out  1  top and mid contain real data (row index ≥ 2)
- valid_o  out  1  output column valid
- ready_i  in  1  downstream accepts

Behaviour:
- Interface decision: one clock, clk_i; reset rst_i is synchronous and active-high. The RAM rstn_i pins are driven by ~rst_i.
- Two RAM instances, each WIDTH_P = PIXEL_WIDTH_P and DEPTH_P = LINE_WIDTH_P:
  - ram_mid holds row y-1.
  - ram_top holds row y-2.
- Pipeline stage S0 (accept):
  - Accept occurs when valid_i & ready_o.
  - On accept: assert rd_en of both RAMs at rd_addr = wr_col; latch pixel_i, wr_col and the row state into S1; set s1_valid.
  - If sof_i is high on the accepted pixel, that pixel is treated as x=0, row=0: column and row counters are forced before use.
- Stage S1 (output):
  - valid_o = s1_valid.
  - col_mid_o / col_top_o are the RAM data_o outputs.
  - col_bot_o is the latched pixel.
- Latency: the column appears exactly 1 cycle after accept.
- ready_o = ~s1_valid | ready_i. This is a single-entry pipeline with no combinational path from valid_i to valid_o.
- Stall behaviour:
  - While valid_o & ~ready_i, rd_en stays low, so RAM data_o and all S1 registers hold stable.
  - No accept occurs during a stall.
- Output fire (valid_o & ready_i):
  - Write ram_mid[col_x] <= col_bot.
  - Write ram_top[col_x] <= col_mid.
  - Clear s1_valid unless a new accept occurs in the same cycle.
- Simultaneous fire and accept:
  - The write is to x and the read is to x+1 (mod LINE_WIDTH_P).
  - Addresses always differ because LINE_WIDTH_P ≥ 2, so there is no same-address hazard.
- Column counter wr_col:
  - Increments on accept.
  - Wraps LINE_WIDTH_P-1 → 0; the row counter increments on wrap.
- Row counter: 2-bit and saturating at 2. rows_valid_o = (S1 row == 2).
- eol_o = (col_x_o == LINE_WIDTH_P-1) while valid_o.
- Reset values:
  - valid_o = 0, ready_o = 1.
  - col_x_o = 0, eol_o = 0, rows_valid_o = 0.
  - col_* outputs = 0, counters = 0.
  - RAM contents are not cleared; rows_valid_o masks the stale data.
- Reset mid-operation drops the S1 entry without writing it. The next accepted pixel is x=0, row=0.
- sof_i mid-line: counters restart and rows_valid_o is deasserted until 2 new lines have been written. Partial-line RAM contents are left as-is.

Decomposition:
- Package line_buffer_pkg holds:
  - pixel_t (logic [PIXEL_WIDTH_P-1:0]);
  - the column_t struct {top, mid, bot};
  - the ROWS_FULL constant = 2.
- Natural sub-module: line_buffer_counter, holding the column/row counters with sof override and row saturation.
- The two RAMs are instantiated directly in line_buffer_ctrl.

Test Plan:
- Streaming, LINE_WIDTH_P=4, ready_i=1, three lines of pixels 0..11 with sof_i on pixel 0 →
  - valid_o 1 cycle after each accept.
  - The third-line column at x=1 has top=1, mid=5, bot=9, rows_valid_o=1.
  - rows_valid_o=0 on lines 0–1.
  - eol_o at x=3.
- Backpressure: ready_i low for 5 cycles mid-line →
  - ready_o=0 and outputs are bit-stable throughout.
  - After release, the next column is correct, with no duplicate or dropped pixels.
- Random valid_i/ready_i over 4 frames of 4×6 → the output stream equals the scoreboard model; no write precedes its read at the same address.
- Reset asserted with s1_valid=1 →
  - Next cycle: valid_o=0, ready_o=1.
  - The first post-reset pixel emits col_x_o=0, rows_valid_o=0.
- sof_i asserted at x=2 of line 2 → that pixel emits col_x_o=0, rows_valid_o=0; rows_valid_o returns on the 3rd line after sof.
- LINE_WIDTH_P=2 back-to-back fire+accept at every cycle for 3 lines → top/mid/bot values are correct, confirming no address collision.
